// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared FSM state type and constants for the radix-2 FP divider
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BIAS      = 127;
    localparam int MANT_W    = 24;
    localparam int QBITS_DEF = 25;

endpackage

// File: rtl/fp_div_unpack.sv
// rtl/fp_div_unpack.sv - split a single-precision operand into sign, exponent and mantissa with hidden bit
module fp_div_unpack
    import fp_div_pkg::*;
(
    input  logic [31:0]       operand,
    output logic              sign,
    output logic [7:0]        exp,
    output logic [MANT_W-1:0] mant
);

    assign sign = operand[31];
    assign exp  = operand[30:23];
    assign mant = {1'b1, operand[22:0]};

endmodule

// File: rtl/fp_div_radix2.sv
// rtl/fp_div_radix2.sv - restoring radix-2 single-precision divider; FP_DIV_SPECIAL_EN adds zero-exponent bypass
module fp_div_radix2
    import fp_div_pkg::*;
#(
    parameter int QBITS = QBITS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A_i,
    input  logic [31:0] B_i,
    output logic        busy,
    output logic        done,
    output logic        S,
    output logic [7:0]  E,
    output logic [22:0] M,
    output logic        dz
);

    localparam int CNT_W = $clog2(QBITS + 1);

    state_t             state, state_nxt;
    logic [25:0]        rem;
    logic [MANT_W-1:0]  div;
    logic [QBITS-1:0]   quot;
    logic [CNT_W-1:0]   cnt;
    logic [7:0]         ea, eb;
    logic               sgn;

    logic               sa, sb;
    logic [7:0]         exp_a, exp_b;
    logic [MANT_W-1:0]  mant_a, mant_b;
    logic               accept;
    logic               ge;

    fp_div_unpack u_unpack_a (.operand(A_i), .sign(sa), .exp(exp_a), .mant(mant_a));
    fp_div_unpack u_unpack_b (.operand(B_i), .sign(sb), .exp(exp_b), .mant(mant_b));

    // A start coinciding with the done pulse is dropped even though busy is low.
    assign accept = (state == IDLE) && start && !done;
    assign busy   = (state != IDLE);
    assign ge     = (rem >= {2'b00, div});

`ifdef FP_DIV_SPECIAL_EN
    logic a_zero, b_zero;
    logic special;
    assign special = (exp_a == 8'd0) || (exp_b == 8'd0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef FP_DIV_SPECIAL_EN
                    state_nxt = special ? NORM : ITER;
`else
                    state_nxt = ITER;
`endif
                end
            end
            ITER:    if (cnt == CNT_W'(QBITS - 1)) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            div  <= '0;
            quot <= '0;
            cnt  <= '0;
            ea   <= '0;
            eb   <= '0;
            sgn  <= 1'b0;
            done <= 1'b0;
            S    <= 1'b0;
            E    <= '0;
            M    <= '0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem  <= {2'b00, mant_a};
                        div  <= mant_b;
                        quot <= '0;
                        cnt  <= '0;
                        ea   <= exp_a;
                        eb   <= exp_b;
                        sgn  <= sa ^ sb;
                    end
                end
                ITER: begin
                    quot <= {quot[QBITS-2:0], ge};
                    rem  <= (ge ? rem - {2'b00, div} : rem) << 1;
                    cnt  <= cnt + 1'b1;
                end
                NORM: begin
                    S <= sgn;
`ifdef FP_DIV_SPECIAL_EN
                    if (b_zero) begin
                        E <= 8'hFF;
                        M <= '0;
                    end else if (a_zero) begin
                        E <= 8'h00;
                        M <= '0;
                    end else
`endif
                    begin
                        // 10-bit exponent math; only the low byte is kept, so it wraps.
                        E <= 8'({2'b00, ea} - {2'b00, eb}
                                + (quot[QBITS-1] ? 10'(BIAS) : 10'(BIAS - 1)));
                        M <= quot[QBITS-1] ? quot[QBITS-2 -: 23] : quot[QBITS-3 -: 23];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FP_DIV_SPECIAL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_zero <= 1'b0;
            b_zero <= 1'b0;
            dz     <= 1'b0;
        end else begin
            if (accept) begin
                a_zero <= (exp_a == 8'd0);
                b_zero <= (exp_b == 8'd0);
            end
            if (state == NORM) dz <= b_zero;
        end
    end
`else
    assign dz = 1'b0;
`endif

endmodule
